// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, schedule size functions, key-expansion FSM states, GF(2^8) xtime.
// The WIPE state exists only when AES_KEY_ZEROIZE_EN is defined.
package aes_pkg;

  localparam logic [1:0] KL_128 = 2'd0;
  localparam logic [1:0] KL_192 = 2'd1;
  localparam logic [1:0] KL_256 = 2'd2;
  localparam logic [1:0] KL_RSV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
`ifdef AES_KEY_ZEROIZE_EN
    , ST_WIPE
`endif
  } state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] total_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return 6'd44;
      KL_192:  return 6'd52;
      KL_256:  return 6'd60;
      default: return 6'd44;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Control/read bus between the AES register bank / round datapath and the key-expansion engine.
interface aes_key_expand_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         zeroize;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   nr;

  modport master (output start, key_len, key_in, zeroize, rk_idx,
                  input  rk_data, busy, done, err, nr);
  modport slave  (input  start, key_len, key_in, zeroize, rk_idx,
                  output rk_data, busy, done, err, nr);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) (as a^254) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // 254 = 240 + 12 + 2, built from a short square/multiply chain
  always_comb begin
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule, one word per cycle, with registered round-key read port.
// Optional AES_KEY_ZEROIZE_EN adds a WIPE state that clears storage on a zeroize pulse.
//
// state  | meaning
// IDLE   | waiting for start; no valid schedule
// LOAD   | cipher key words w[0..Nk-1] written in one cycle
// EXPAND | one derived word w[i] per cycle until i == T-1
// DONE   | schedule valid, round keys readable
// WIPE   | (zeroize build) clearing one storage word per cycle
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int MAX_WORDS = 60
) (
  input  logic            s00_axi_aclk,
  input  logic            s00_axi_aresetn,
  aes_key_expand_if.slave bus
);

  state_t       state_q, state_d;
  logic [1:0]   kl_q;
  logic [5:0]   idx_q;
  logic [2:0]   mod_q;
  logic [7:0]   rcon_q;
  logic [31:0]  win_q [8];
  logic [31:0]  mem   [MAX_WORDS];
  logic         busy_q, done_q, err_q;
  logic         busy_d, done_d, err_d;
  logic [3:0]   nr_q, nr_d;
  logic [127:0] rk_q;

  logic [3:0]   nk;
  logic [5:0]   total;
  logic         last_word;
  logic         go;
  logic [31:0]  kw [8];
  logic [31:0]  prev, back, rot, sub_in, sub_out, temp, new_word;
  logic         rd_ok;
  logic [5:0]   base;

`ifdef AES_KEY_ZEROIZE_EN
  logic [5:0]   wipe_q;
`else
  logic         unused_zeroize;
  assign unused_zeroize = bus.zeroize;
`endif

  assign nk        = nk_of(kl_q);
  assign total     = total_of(kl_q);
  assign last_word = (idx_q == total - 6'd1);

  always_comb begin
    for (int j = 0; j < 8; j++) kw[j] = bus.key_in[255 - 32*j -: 32];
  end

  // win_q[7] is w[i-1]; w[i-Nk] sits Nk-1 places below it
  always_comb begin
    prev = win_q[7];
    case (kl_q)
      KL_192:  back = win_q[2];
      KL_256:  back = win_q[0];
      default: back = win_q[4];
    endcase
    rot    = {prev[23:0], prev[31:24]};
    sub_in = (mod_q == 3'd0) ? rot : prev;
    if (mod_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (kl_q == KL_256 && mod_q == 3'd4)
      temp = sub_out;
    else
      temp = prev;
    new_word = back ^ temp;
  end

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .s(sub_out[8*b +: 8]));
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    go      = bus.start;
`ifdef AES_KEY_ZEROIZE_EN
    if (bus.zeroize) go = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go && bus.key_len == KL_RSV) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (go) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
        end
      end
      ST_LOAD:   state_d = ST_EXPAND;
      ST_EXPAND: if (last_word) state_d = ST_DONE;
`ifdef AES_KEY_ZEROIZE_EN
      ST_WIPE:   if (wipe_q == 6'(MAX_WORDS - 1)) state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
`ifdef AES_KEY_ZEROIZE_EN
    if (bus.zeroize && state_q != ST_WIPE) state_d = ST_WIPE;
`endif
    busy_d = (state_d == ST_LOAD) || (state_d == ST_EXPAND);
`ifdef AES_KEY_ZEROIZE_EN
    if (state_d == ST_WIPE) busy_d = 1'b1;
`endif
    done_d = (state_d == ST_DONE);
    nr_d   = done_d ? nr_of(kl_q) : 4'd0;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q <= ST_IDLE;
      kl_q    <= KL_128;
      idx_q   <= 6'd0;
      mod_q   <= 3'd0;
      rcon_q  <= 8'h00;
      for (int j = 0; j < 8; j++) win_q[j] <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      nr_q    <= 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
      wipe_q  <= 6'd0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      nr_q    <= nr_d;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (state_d == ST_LOAD) kl_q <= bus.key_len;
        end
        ST_LOAD: begin
          idx_q  <= {2'b00, nk};
          mod_q  <= 3'd0;
          rcon_q <= 8'h01;
          case (kl_q)
            KL_256:  for (int j = 0; j < 8; j++) win_q[j]     <= kw[j];
            KL_192:  for (int j = 0; j < 6; j++) win_q[j + 2] <= kw[j];
            default: for (int j = 0; j < 4; j++) win_q[j + 4] <= kw[j];
          endcase
        end
        ST_EXPAND: begin
          for (int j = 0; j < 7; j++) win_q[j] <= win_q[j + 1];
          win_q[7] <= new_word;
          idx_q    <= idx_q + 6'd1;
          mod_q    <= (mod_q == 3'(nk - 4'd1)) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
        end
`ifdef AES_KEY_ZEROIZE_EN
        ST_WIPE: begin
          wipe_q <= wipe_q + 6'd1;
          if (state_d != ST_WIPE) begin
            wipe_q <= 6'd0;
            rcon_q <= 8'h00;
            for (int j = 0; j < 8; j++) win_q[j] <= 32'h0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only the FSM decides what is written
  always_ff @(posedge s00_axi_aclk) begin
    case (state_q)
      ST_LOAD:   for (int j = 0; j < 8; j++) if (4'(j) < nk) mem[j] <= kw[j];
      ST_EXPAND: mem[idx_q] <= new_word;
`ifdef AES_KEY_ZEROIZE_EN
      ST_WIPE:   mem[wipe_q] <= 32'h0;
`endif
      default: ;
    endcase
  end

  assign rd_ok = done_q && (bus.rk_idx <= nr_q);
  assign base  = rd_ok ? {bus.rk_idx, 2'b00} : 6'd0;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn)
      rk_q <= 128'h0;
    else if (rd_ok)
      rk_q <= {mem[base], mem[base + 6'd1], mem[base + 6'd2], mem[base + 6'd3]};
    else
      rk_q <= 128'h0;
  end

  assign bus.rk_data = rk_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.nr      = nr_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 vectors, latency, error, ignored restart and reset abort.
// Round-key reads are checked through a scoreboard queue drained by a separate monitor.
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_expand_if bus ();

  aes_key_expand dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .bus            (bus)
  );

  typedef struct {
    logic [127:0] exp;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic req = 1'b0;
  logic req_q1 = 1'b0;

  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'hffffffffffffffffffffffffffffffff};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hdeadbeefcafef00d};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) req_q1 <= req;

  always @(negedge clk) begin
    exp_t e;
    if (req_q1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: read returned %h with nothing expected", bus.rk_data);
      end else begin
        e = sb.pop_front();
        chk(e.name, bus.rk_data, e.exp);
      end
    end
  end

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    bus.rk_idx = idx;
    req = 1'b1;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic rd_end();
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
  endtask

  // Returns the cycle after the start cycle at which done was first seen (or the abort cycle)
  task automatic run(input logic [1:0] kl, input logic [255:0] key, input int abort_at,
                     input int restart_at, output int cyc);
    bit aborted;
    aborted = 1'b0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = kl;
    bus.key_in  = key;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      bus.start   = (cyc == restart_at);
      bus.key_len = (cyc == restart_at) ? 2'd2 : kl;
      if (cyc == abort_at) begin
        chk("busy_before_rst", 128'(bus.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_err",  128'(bus.err),  128'd0);
        chk("rst_nr",   128'(bus.nr),   128'd0);
        chk("rst_rk",   bus.rk_data,    128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
      end
    end while (!aborted && !bus.done && cyc < 200);
    bus.start = 1'b0;
  endtask

  initial begin
    int cyc;
    bus.start   = 1'b0;
    bus.key_len = 2'd0;
    bus.key_in  = '0;
    bus.zeroize = 1'b0;
    bus.rk_idx  = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_done", 128'(bus.done), 128'd0);
    chk("reset_err",  128'(bus.err),  128'd0);
    chk("reset_nr",   128'(bus.nr),   128'd0);
    chk("reset_rk",   bus.rk_data,    128'd0);

    // AES-128
    run(2'd0, KEY128, 0, 0, cyc);
    chk("lat128", 128'(cyc), 128'd42);
    chk("nr128", 128'(bus.nr), 128'd10);
    chk("busy128", 128'(bus.busy), 128'd0);
    rd(4'd0,  128'h000102030405060708090a0b0c0d0e0f, "k128_r0");
    rd(4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "k128_r1");
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "k128_r10");
    rd(4'd11, 128'h0, "k128_r11_out");
    rd(4'd15, 128'h0, "k128_r15_out");
    rd_end();

    // AES-192
    run(2'd1, KEY192, 0, 0, cyc);
    chk("lat192", 128'(cyc), 128'd48);
    chk("nr192", 128'(bus.nr), 128'd12);
    rd(4'd0,  128'h000102030405060708090a0b0c0d0e0f, "k192_r0");
    rd(4'd1,  128'h10111213141516175846f2f95c43f4fe, "k192_r1");
    rd(4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d, "k192_r12");
    rd(4'd13, 128'h0, "k192_r13_out");
    rd_end();

    // Reserved key length
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = 2'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("rsv_err",  128'(bus.err),  128'd1);
    chk("rsv_done", 128'(bus.done), 128'd0);
    chk("rsv_busy", 128'(bus.busy), 128'd0);
    chk("rsv_nr",   128'(bus.nr),   128'd0);
    rd(4'd12, 128'h0, "rsv_r12");
    rd(4'd0,  128'h0, "rsv_r0");
    rd_end();

    // AES-256
    run(2'd2, KEY256, 0, 0, cyc);
    chk("lat256", 128'(cyc), 128'd54);
    chk("nr256", 128'(bus.nr), 128'd14);
    chk("err_cleared", 128'(bus.err), 128'd0);
    rd(4'd0,  128'h000102030405060708090a0b0c0d0e0f, "k256_r0");
    rd(4'd1,  128'h101112131415161718191a1b1c1d1e1f, "k256_r1");
    rd(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "k256_r14");
    rd(4'd15, 128'h0, "k256_r15_out");
    rd_end();

    // Start 10 cycles into an AES-128 run must be ignored
    run(2'd0, KEY128, 0, 10, cyc);
    chk("lat128_restart", 128'(cyc), 128'd42);
    chk("nr128_restart", 128'(bus.nr), 128'd10);
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "restart_r10");
    rd(4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "restart_r1");
    rd_end();

    // Reset at cycle 20 of an AES-256 run, then a clean AES-128 restart
    run(2'd2, KEY256, 20, 0, cyc);
    run(2'd0, KEY128, 0, 0, cyc);
    chk("lat128_after_rst", 128'(cyc), 128'd42);
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "after_rst_r10");
    rd_end();

`ifdef AES_KEY_ZEROIZE_EN
    run(2'd2, KEY256, 0, 0, cyc);
    chk("lat256_z", 128'(cyc), 128'd54);
    @(negedge clk);
    bus.zeroize = 1'b1;
    @(posedge clk);
    #1;
    bus.zeroize = 1'b0;
    cyc = 1;
    chk("wipe_done", 128'(bus.done), 128'd0);
    chk("wipe_nr",   128'(bus.nr),   128'd0);
    while (bus.busy && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("wipe_busy_cycles", 128'(cyc - 1), 128'd60);
    chk("wipe_done_after", 128'(bus.done), 128'd0);
    for (int r = 0; r < 15; r++) rd(4'(r), 128'h0, "wipe_read");
    rd_end();
`endif

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: %0d reads never returned, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
